// File: rtl/debug_serial_pkg.sv
// Shared types and helpers for the debug serial link scheduler.
package debug_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DATA_W     = 16;
    localparam int unsigned DEFAULT_GAP_CYCLES = 2;

    // Channel ID field width; a single channel still sends one ID bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/debug_serial_scheduler_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter
    import debug_serial_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned ID_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   idx,
    output logic              any
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [NUM_CH-1:0] rot;
    logic [ID_W-1:0]   off;
    logic [SUM_W-1:0]  sum;

    assign any = |req;

    // Rotate so the pointer sits at bit 0, pick the lowest set bit, map back to a channel
    always_comb begin
        rot = NUM_CH'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SUM_W'(NUM_CH)) sum = sum - SUM_W'(NUM_CH);
        idx   = sum[ID_W-1:0];
        grant = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (any && (idx == ID_W'(ch))) grant[ch] = 1'b1;
        end
    end

endmodule

// File: rtl/debug_serial_scheduler.sv
// Round-robin scheduler sharing one debug serial link between NUM_CH counters.
// Frame: channel ID then data, MSB first. Build option SERIAL_PARITY_EN appends
// an even-parity bit over {ID, DATA}.
module debug_serial_scheduler
    import debug_serial_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                     CLK_3P3_MHZ,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        REQ,
    input  logic [NUM_CH*DATA_W-1:0] DATA,
    output logic [NUM_CH-1:0]        ACK,
    output logic                     OUTPUT_ENABLED,
    output logic                     SERIAL_OUT,
    output logic                     BUSY
);

    localparam int unsigned ID_W = id_width(NUM_CH);
`ifdef SERIAL_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned FRAME_LEN = ID_W + DATA_W + PAR_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 16);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]    ack_d;
    logic                 oe_d, sout_d, busy_d;

    logic [NUM_CH-1:0]    grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 any_req;
    logic [DATA_W-1:0]    data_sel;
    logic [FRAME_LEN-1:0] word;
    logic                 last_bit, last_gap;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (REQ),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_req)
    );

    // Select the granted channel's payload and build the frame word
    always_comb begin
        data_sel = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (grant[ch]) data_sel = DATA[ch*DATA_W +: DATA_W];
        end
`ifdef SERIAL_PARITY_EN
        word = {grant_idx, data_sel, ^{grant_idx, data_sel}};
`else
        word = {grant_idx, data_sel};
`endif
    end

    assign last_bit = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign last_gap = (cnt_q == CNT_W'(GAP_CYCLES - 1));

    // State register
    always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (last_gap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; registered below
    always_comb begin
        ptr_d  = ptr_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        ack_d  = '0;
        oe_d   = 1'b0;
        sout_d = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sr_d  = word;
                    ack_d = grant;
                    cnt_d = '0;
                    ptr_d = (grant_idx == ID_W'(NUM_CH - 1)) ? '0 : grant_idx + ID_W'(1);
                end
            end
            SHIFT: begin
                oe_d   = 1'b1;
                sout_d = sr_q[FRAME_LEN-1];
                sr_d   = sr_q << 1;
                cnt_d  = last_bit ? '0 : cnt_q + CNT_W'(1);
            end
            GAP: begin
                cnt_d = last_gap ? '0 : cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
        if (RESET) begin
            ptr_q          <= '0;
            sr_q           <= '0;
            cnt_q          <= '0;
            ACK            <= '0;
            OUTPUT_ENABLED <= 1'b0;
            SERIAL_OUT     <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            ACK            <= ack_d;
            OUTPUT_ENABLED <= oe_d;
            SERIAL_OUT     <= sout_d;
            BUSY           <= busy_d;
        end
    end

endmodule

// File: tb/tb_debug_serial_scheduler.sv
// Directed bench for debug_serial_scheduler (NUM_CH=4, DATA_W=16, GAP_CYCLES=2).
module tb_debug_serial_scheduler;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned GAP    = 2;
`ifdef SERIAL_PARITY_EN
    localparam int unsigned FLEN = 19;
`else
    localparam int unsigned FLEN = 18;
`endif
    localparam int unsigned PERIOD = FLEN + GAP + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  ack;
    logic        oe, sout, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_prev;
    logic [31:0] expv;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  id;
        logic [15:0] d;
        logic        par;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_serial_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(GAP)
    ) dut (
        .CLK_3P3_MHZ    (clk),
        .RESET          (rst),
        .REQ            (req),
        .DATA           (data),
        .ACK            (ack),
        .OUTPUT_ENABLED (oe),
        .SERIAL_OUT     (sout),
        .BUSY           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name, input logic [3:0] exp);
        int n;
        n = 0;
        tick();
        while (ack == 4'b0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(ack), 32'(exp));
    endtask

    task automatic get_frame(input string name, input logic [31:0] exp);
        logic [31:0] bits;
        int hi;
        bits = '0;
        hi   = 0;
        for (int b = 0; b < int'(FLEN); b++) begin
            tick();
            if (b == 0) check({name, " ack_pulse"}, 32'(ack), 32'd0);
            if (oe) hi++;
            bits = {bits[30:0], sout};
        end
        check({name, " oe_cycles"}, 32'(hi), FLEN);
        check({name, " bits"}, bits, exp);
        tick();
        check({name, " oe_after"}, 32'(oe), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0100, 2'd2, 16'hA5C3, 1'b1};
        vecs[1] = '{4'b1000, 2'd3, 16'hFFFF, 1'b0};
        vecs[2] = '{4'b0010, 2'd1, 16'h0007, 1'b0};
        vecs[3] = '{4'b0001, 2'd0, 16'h8000, 1'b1};
        vecs[4] = '{4'b0010, 2'd1, 16'h1234, 1'b0};

        rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (3) tick();
        check("reset ack", 32'(ack), 32'd0);
        check("reset oe", 32'(oe), 32'd0);
        check("reset sout", 32'(sout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // All requests held: strict rotation at a fixed frame period
        data = {16'h3333, 16'h2222, 16'h1111, 16'h0F00};
        req  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_ack($sformatf("rr grant %0d", i), 4'(1 << (i % 4)));
            if (i > 0) check($sformatf("rr spacing %0d", i), 32'(cyc - t_prev), PERIOD);
            t_prev = cyc;
        end
        req = '0;
        wait_idle("rr idle");

        // Single-request table
        for (int i = 0; i < 5; i++) begin
            data = 64'(vecs[i].d) << (16 * int'(vecs[i].id));
            req  = vecs[i].req;
            wait_ack($sformatf("vec%0d ack", i), vecs[i].req);
            req = '0;
`ifdef SERIAL_PARITY_EN
            expv = 32'({vecs[i].id, vecs[i].d, vecs[i].par});
`else
            expv = 32'({vecs[i].id, vecs[i].d});
`endif
            get_frame($sformatf("vec%0d", i), expv);
            tick();
            tick();
            check($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d idle oe", i), 32'(oe), 32'd0);
        end

        // Requests raised during a channel-2 frame: channel 3 before channel 1
        data = {16'hBEEF, 16'h5555, 16'h0F0F, 16'h0000};
        req  = 4'b0100;
        wait_ack("pend ch2", 4'b0100);
        req = '0;
        repeat (5) tick();
        req = 4'b1010;
        wait_ack("pend ch3 first", 4'b1000);
        req = 4'b0010;
`ifdef SERIAL_PARITY_EN
        get_frame("pend ch3", 32'({2'b11, 16'hBEEF, 1'b1}));
`else
        get_frame("pend ch3", 32'({2'b11, 16'hBEEF}));
`endif
        wait_ack("pend ch1 second", 4'b0010);
        req = '0;
`ifdef SERIAL_PARITY_EN
        get_frame("pend ch1", 32'({2'b01, 16'h0F0F, 1'b1}));
`else
        get_frame("pend ch1", 32'({2'b01, 16'h0F0F}));
`endif
        wait_idle("pend idle");

        // DATA changing after capture must not reach the frame
        data = 64'h0001;
        req  = 4'b0001;
        wait_ack("hold ch0 ack", 4'b0001);
        data = 64'hFFFF;
        req  = '0;
`ifdef SERIAL_PARITY_EN
        get_frame("data change", 32'({2'b00, 16'h0001, 1'b1}));
`else
        get_frame("data change", 32'({2'b00, 16'h0001}));
`endif
        wait_idle("data change idle");

        // Reset in the middle of a frame
        data = {16'h0000, 16'hA5C3, 16'h0000, 16'h8421};
        req  = 4'b0100;
        wait_ack("rst ch2 ack", 4'b0100);
        req = '0;
        for (int b = 0; b < 8; b++) tick();
        check("bit7 oe", 32'(oe), 32'd1);
        check("bit7 value", 32'(sout), 32'd1);
        req = 4'b0011;
        #2 rst = 1'b1;
        #1;
        check("async rst oe", 32'(oe), 32'd0);
        check("async rst sout", 32'(sout), 32'd0);
        check("async rst ack", 32'(ack), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        wait_ack("post rst lowest", 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("async rst ack pulse", 32'(ack), 32'd0);
        tick();
        rst = 1'b0;
        wait_ack("post rst2 lowest", 4'b0001);
        req = 4'b0010;
`ifdef SERIAL_PARITY_EN
        get_frame("post rst ch0", 32'({2'b00, 16'h8421, 1'b0}));
`else
        get_frame("post rst ch0", 32'({2'b00, 16'h8421}));
`endif
        wait_ack("post rst ch1", 4'b0010);
        req = '0;
`ifdef SERIAL_PARITY_EN
        get_frame("post rst ch1", 32'({2'b01, 16'h0000, 1'b1}));
`else
        get_frame("post rst ch1", 32'({2'b01, 16'h0000}));
`endif
        wait_idle("final idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
